// File: rtl/spm_seq_mul_if.sv
// spm_seq_mul_if: request/result bundle of the serial-parallel multiplier.
// Handshake: a request is start=1 while busy=0; it is taken on that clock
// edge and busy rises on the next cycle. start seen while busy=1 is dropped,
// never queued. Results appear as p_bit qualified by p_vld, then a one-cycle
// done pulse with prod. The acc input exists only when SPM_ACC_EN is defined.
// state_dbg mirrors the internal FSM state for observation.
interface spm_seq_mul_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               sgn;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               abort;
`ifdef SPM_ACC_EN
    logic               acc;
`endif
    logic               busy;
    logic               p_bit;
    logic               p_vld;
    logic               done;
    logic [2*WIDTH-1:0] prod;
    logic [1:0]         state_dbg;

    modport master (
        output start, sgn, x, y, abort,
`ifdef SPM_ACC_EN
        output acc,
`endif
        input  busy, p_bit, p_vld, done, prod, state_dbg
    );

    modport slave (
        input  start, sgn, x, y, abort,
`ifdef SPM_ACC_EN
        input  acc,
`endif
        output busy, p_bit, p_vld, done, prod, state_dbg
    );
endinterface

// File: rtl/spm_seq_mul.sv
// spm_seq_mul: serial-parallel multiplier. The multiplicand is held in
// parallel (extended to 2*WIDTH), the multiplier is shifted in LSB first,
// and the 2*WIDTH-bit product leaves one bit per clock, LSB first. After the
// last bit the full product is presented on prod with a done pulse.
// Optional feature macro: SPM_ACC_EN (adds an acc input; DONE may add the
// new result to the previous prod instead of replacing it).
module spm_seq_mul #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    spm_seq_mul_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(PW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;      // index of the bit currently on p_bit
    logic [PW-1:0]    xe;       // extended multiplicand
    logic [PW-1:0]    sum;      // running partial sum, already shifted by cnt+1
    logic [PW-1:0]    shreg;    // collects emitted bits for the parallel result
    logic [WIDTH-1:0] yr;       // multiplier, shifted right with sign/zero fill
    logic             sgn_r;
    logic             busy_r;
    logic             done_r;
    logic             pbit_r;
    logic             pvld_r;
    logic [PW-1:0]    prod_r;
`ifdef SPM_ACC_EN
    logic             acc_r;
`endif

    logic [PW-1:0]    x_ext_in;
    logic [PW-1:0]    t_first;
    logic [PW-1:0]    t_run;
    logic [PW-1:0]    prod_nxt;

    // Step arithmetic: first bit from the raw inputs, later bits from registers.
    always_comb begin
        x_ext_in = bus.sgn ? {{WIDTH{bus.x[WIDTH-1]}}, bus.x}
                           : {{WIDTH{1'b0}}, bus.x};
        t_first  = bus.y[0] ? x_ext_in : '0;
        t_run    = sum + (yr[0] ? xe : '0);
`ifdef SPM_ACC_EN
        prod_nxt = acc_r ? (prod_r + shreg) : shreg;
`else
        prod_nxt = shreg;
`endif
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            xe     <= '0;
            sum    <= '0;
            shreg  <= '0;
            yr     <= '0;
            sgn_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pbit_r <= 1'b0;
            pvld_r <= 1'b0;
            prod_r <= '0;
`ifdef SPM_ACC_EN
            acc_r  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // start wins over abort here; abort has nothing to cancel
                    if (bus.start) begin
                        state  <= S_RUN;
                        busy_r <= 1'b1;
                        xe     <= x_ext_in;
                        yr     <= {bus.sgn & bus.y[WIDTH-1], bus.y[WIDTH-1:1]};
                        sgn_r  <= bus.sgn;
                        cnt    <= '0;
                        pbit_r <= t_first[0];
                        pvld_r <= 1'b1;
                        sum    <= {1'b0, t_first[PW-1:1]};
                        shreg  <= {t_first[0], shreg[PW-1:1]};
`ifdef SPM_ACC_EN
                        acc_r  <= bus.acc;
`endif
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                        pvld_r <= 1'b0;
                        pbit_r <= 1'b0;
                        cnt    <= '0;
                        xe     <= '0;
                        sum    <= '0;
                        shreg  <= '0;
                        yr     <= '0;
                    end else if (cnt == LAST) begin
                        state  <= S_DONE;
                        pvld_r <= 1'b0;
                        pbit_r <= 1'b0;
                        done_r <= 1'b1;
                        prod_r <= prod_nxt;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        pbit_r <= t_run[0];
                        sum    <= {1'b0, t_run[PW-1:1]};
                        shreg  <= {t_run[0], shreg[PW-1:1]};
                        yr     <= {sgn_r & yr[WIDTH-1], yr[WIDTH-1:1]};
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    sum    <= '0;
                    cnt    <= '0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    pvld_r <= 1'b0;
                    pbit_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.p_bit     = pbit_r;
    assign bus.p_vld     = pvld_r;
    assign bus.prod      = prod_r;
    assign bus.state_dbg = state;
endmodule
